lce_pixel_sequencer: RTL and testbench

LCE_PIXEL_SEQUENCER -- requirements
Module: lce_pixel_sequencer

---
 rtl/lce_pkg.sv | 27 ++
 rtl/lce_pixel_sequencer_if.sv | 33 +++
 rtl/lce_raster_counter.sv | 43 ++++
 rtl/lce_pixel_sequencer.sv | 103 ++++++++++
 tb/tb_lce_pixel_sequencer.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lce_pkg.sv
// lce_pkg: shared definitions for the LCE pixel sequencer.
// Holds the sequencer state enumeration, default image dimensions, the
// row/column/pixel-index widths and a helper for the final pixel index.
package lce_pkg;

    localparam int IMG_W_DEF = 150;
    localparam int IMG_H_DEF = 150;
    localparam int PIX_W     = 15;
    localparam int ROW_W     = 8;
    localparam int COL_W     = 8;

    typedef enum logic [2:0] {
        IDLE,
        WIN,
        HIST,
        CDF,
        WR,
        NEXT,
        FIN
    } state_t;

    // Linear index of the bottom-right pixel of a w x h image.
    function automatic logic [PIX_W-1:0] last_pix(input int w, input int h);
        return PIX_W'(w * h - 1);
    endfunction

endpackage

// File: rtl/lce_pixel_sequencer_if.sv
// lce_pixel_sequencer_if: stage handshake bundle between the sequencer and
// the window/histogram/CDF datapath.
//   win_go/win_done   : load 3x3 window request / loaded
//   hist_go/hist_done : local histogram request / complete
//   cdf_go/cdf_done   : CDF mapping request / mapped value valid
//   wr_en             : write mapped pixel at pix_idx
//   row/col/pix_idx   : current raster position
// master = sequencer side, slave = datapath side.
interface lce_pixel_sequencer_if;
    import lce_pkg::*;

    logic             win_go;
    logic             win_done;
    logic             hist_go;
    logic             hist_done;
    logic             cdf_go;
    logic             cdf_done;
    logic             wr_en;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [PIX_W-1:0] pix_idx;

    modport master (
        output win_go, hist_go, cdf_go, wr_en, row, col, pix_idx,
        input  win_done, hist_done, cdf_done
    );

    modport slave (
        input  win_go, hist_go, cdf_go, wr_en, row, col, pix_idx,
        output win_done, hist_done, cdf_done
    );

endinterface

// File: rtl/lce_raster_counter.sv
// lce_raster_counter: raster-order position counter for the sequencer.
//   clk, re  : clock, asynchronous active-low reset
//   clr      : zero all counters (frame start)
//   adv      : step to the next pixel in raster order
//   row, col : current position
//   pix_idx  : row*IMG_W+col, kept as its own incrementing counter
module lce_raster_counter
    import lce_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF
) (
    input  logic             clk,
    input  logic             re,
    input  logic             clr,
    input  logic             adv,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic [PIX_W-1:0] pix_idx
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

    always_ff @(posedge clk or negedge re) begin
        if (!re) begin
            row     <= '0;
            col     <= '0;
            pix_idx <= '0;
        end else if (clr) begin
            row     <= '0;
            col     <= '0;
            pix_idx <= '0;
        end else if (adv) begin
            pix_idx <= pix_idx + 1'b1;
            if (col == COL_LAST) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lce_pixel_sequencer.sv
// lce_pixel_sequencer: per-pixel control sequencer for local contrast
// enhancement. Walks the image in raster order and, for every pixel, runs
// window load -> histogram -> CDF mapping -> write, then advances.
//   clk, re     : clock, asynchronous active-low reset
//   start       : one-cycle frame start (ignored while busy)
//   pause       : holds sequencing at the next pixel boundary
//   sif         : stage handshakes and raster position (master side)
//   busy        : high in every state except IDLE
//   frame_done  : one-cycle pulse after the last pixel is written
module lce_pixel_sequencer
    import lce_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic                  clk,
    input  logic                  re,
    input  logic                  start,
    input  logic                  pause,
    lce_pixel_sequencer_if.master sif,
    output logic                  busy,
    output logic                  frame_done
);

    localparam logic [PIX_W-1:0] LAST = last_pix(IMG_W, IMG_H);

    state_t state;
    logic   clr;
    logic   adv;

    // Counters move on the same edges as the matching state transitions, so
    // the position is already valid in the first WIN cycle of each pixel.
    assign clr = (state == IDLE) && start;
    assign adv = (state == NEXT) && !pause;

    lce_raster_counter #(.IMG_W(IMG_W)) u_cnt (
        .clk     (clk),
        .re      (re),
        .clr     (clr),
        .adv     (adv),
        .row     (sif.row),
        .col     (sif.col),
        .pix_idx (sif.pix_idx)
    );

    // Each go register is high exactly in the first cycle of its state, so
    // it doubles as the "ignore done in the go cycle" qualifier.
    always_ff @(posedge clk or negedge re) begin
        if (!re) begin
            state       <= IDLE;
            sif.win_go  <= 1'b0;
            sif.hist_go <= 1'b0;
            sif.cdf_go  <= 1'b0;
            sif.wr_en   <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            sif.win_go  <= 1'b0;
            sif.hist_go <= 1'b0;
            sif.cdf_go  <= 1'b0;
            sif.wr_en   <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state      <= WIN;
                    sif.win_go <= 1'b1;
                    busy       <= 1'b1;
                end
                WIN: if (sif.win_done && !sif.win_go) begin
                    state       <= HIST;
                    sif.hist_go <= 1'b1;
                end
                HIST: if (sif.hist_done && !sif.hist_go) begin
                    state      <= CDF;
                    sif.cdf_go <= 1'b1;
                end
                CDF: if (sif.cdf_done && !sif.cdf_go) begin
                    state     <= WR;
                    sif.wr_en <= 1'b1;
                end
                WR: if (sif.pix_idx == LAST) begin
                    state      <= FIN;
                    frame_done <= 1'b1;
                end else begin
                    state <= NEXT;
                end
                NEXT: if (!pause) begin
                    state      <= WIN;
                    sif.win_go <= 1'b1;
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lce_pixel_sequencer.sv
// tb_lce_pixel_sequencer: self-checking bench for lce_pixel_sequencer.
// A 150x5 image keeps a full frame short while still exercising column wrap
// and pixel 500. Stage responders answer each go after a fixed or random
// delay; expected event order, timing and raster positions come from plain
// arithmetic on the pixel number.
module tb_lce_pixel_sequencer;
    import lce_pkg::*;

    localparam int W = 150;
    localparam int H = 5;
    localparam int N = W * H;

    localparam int K_WG = 0;
    localparam int K_WD = 1;
    localparam int K_HG = 2;
    localparam int K_HD = 3;
    localparam int K_CG = 4;
    localparam int K_CD = 5;
    localparam int K_WR = 6;
    localparam int K_FD = 7;

    typedef struct {
        int cyc;
        int kind;
        int pix;
        int row;
        int col;
    } ev_t;

    logic clk   = 1'b0;
    logic re    = 1'b1;
    logic start = 1'b0;
    logic pause = 1'b0;
    logic busy;
    logic frame_done;
    logic r_win  = 1'b0;
    logic r_hist = 1'b0;
    logic r_cdf  = 1'b0;
    logic s_win  = 1'b0;
    logic s_hist = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int resp_d = 0;
    int viol   = 0;
    int n_ev[8];
    int last_cyc[8];
    int last_pix[8];
    ev_t evq[$];

    lce_pixel_sequencer_if sif ();

    assign sif.win_done  = r_win | s_win;
    assign sif.hist_done = r_hist | s_hist;
    assign sif.cdf_done  = r_cdf;

    lce_pixel_sequencer #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .re         (re),
        .start      (start),
        .pause      (pause),
        .sif        (sif),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log of every pulse, stamped with the number of rising edges seen.
    always @(negedge clk) begin
        logic [7:0] k;
        ev_t e;
        k = {frame_done, sif.wr_en, sif.cdf_done, sif.cdf_go,
             sif.hist_done, sif.hist_go, sif.win_done, sif.win_go};
        if ($countones({k[0], k[2], k[4], k[6], k[7]}) > 1) viol++;
        for (int i = 0; i < 8; i++) begin
            if (k[i]) begin
                e.cyc = cyc;
                e.kind = i;
                e.pix = int'(sif.pix_idx);
                e.row = int'(sif.row);
                e.col = int'(sif.col);
                evq.push_back(e);
                n_ev[i]++;
                last_cyc[i] = cyc;
                last_pix[i] = int'(sif.pix_idx);
            end
        end
    end

    // Stage responder: answers a go with its done resp_d cycles later
    // (random 1..3 when resp_d is 0).
    initial begin
        int cnt;
        int typ;
        cnt = 0;
        typ = 0;
        forever begin
            @(posedge clk);
            #1;
            r_win  = 1'b0;
            r_hist = 1'b0;
            r_cdf  = 1'b0;
            if (!re) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        if (typ == 0) r_win = 1'b1;
                        else if (typ == 1) r_hist = 1'b1;
                        else r_cdf = 1'b1;
                    end
                end
                if (sif.win_go || sif.hist_go || sif.cdf_go) begin
                    typ = sif.win_go ? 0 : (sif.hist_go ? 1 : 2);
                    cnt = (resp_d > 0) ? resp_d : int'($urandom_range(3, 1));
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, got time=%0t required=finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(output int t);
        tick();
        start = 1'b1;
        t = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        re = 1'b0;
        pause = 1'b0;
        s_win = 1'b0;
        s_hist = 1'b0;
        tick();
        tick();
        re = 1'b1;
    endtask

    task automatic test_reset();
        int wg0;
        #2;
        re = 1'b0;
        #1;
        checks++;
        if ({busy, frame_done, sif.win_go, sif.hist_go, sif.cdf_go, sif.wr_en} !== 6'b0) begin
            errors++;
            $display("FAIL reset_pulses got=%b required=000000",
                     {busy, frame_done, sif.win_go, sif.hist_go, sif.cdf_go, sif.wr_en});
        end
        checks++;
        if (sif.row !== 8'd0 || sif.col !== 8'd0 || sif.pix_idx !== 15'd0) begin
            errors++;
            $display("FAIL reset_counters got row=%0d col=%0d pix=%0d required 0/0/0",
                     sif.row, sif.col, sif.pix_idx);
        end
        repeat (3) tick();
        re = 1'b1;
        wg0 = n_ev[K_WG];
        repeat (4) tick();
        checks++;
        if (busy !== 1'b0 || n_ev[K_WG] != wg0) begin
            errors++;
            $display("FAIL idle_without_start got busy=%b win_go_count=%0d required busy=0 count=%0d",
                     busy, n_ev[K_WG], wg0);
        end
    endtask

    task automatic test_first_pixel();
        int t;
        int base;
        int ec[7];
        ec = '{1, 3, 4, 6, 7, 9, 10};
        resp_d = 2;
        base = evq.size();
        pulse_start(t);
        for (int i = 0; i < 200 && evq.size() < base + 7; i++) tick();
        checks++;
        if (evq.size() < base + 7) begin
            errors++;
            $display("FAIL first_pixel_timeout got events=%0d required=%0d", evq.size() - base, 7);
        end else begin
            for (int j = 0; j < 7; j++) begin
                checks++;
                if (evq[base + j].kind != j || evq[base + j].cyc != t + ec[j]) begin
                    errors++;
                    $display("FAIL first_pixel_event%0d got kind=%0d at +%0d required kind=%0d at +%0d",
                             j, evq[base + j].kind, evq[base + j].cyc - t, j, ec[j]);
                end
            end
            checks++;
            if (evq[base + 6].pix != 0 || evq[base + 6].row != 0 || evq[base + 6].col != 0) begin
                errors++;
                $display("FAIL first_wr_pos got pix=%0d row=%0d col=%0d required 0/0/0",
                         evq[base + 6].pix, evq[base + 6].row, evq[base + 6].col);
            end
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL first_pixel_busy got=%b required=1", busy);
        end
        do_reset();
    endtask

    task automatic test_full_frame();
        int t;
        int base;
        int idx;
        int prev;
        int fd0;
        int wr0;
        int v0;
        resp_d = 0;
        v0 = viol;
        fd0 = n_ev[K_FD];
        wr0 = n_ev[K_WR];
        base = evq.size();
        pulse_start(t);
        for (int i = 0; i < N * 16 && n_ev[K_FD] == fd0; i++) tick();
        checks++;
        if (n_ev[K_FD] == fd0) begin
            errors++;
            $display("FAIL frame_timeout got frame_done=0 required=1");
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_frame got=%b required=0", busy);
        end
        checks++;
        if (n_ev[K_WR] - wr0 != N || n_ev[K_FD] - fd0 != 1) begin
            errors++;
            $display("FAIL frame_counts got wr=%0d fd=%0d required wr=%0d fd=1",
                     n_ev[K_WR] - wr0, n_ev[K_FD] - fd0, N);
        end
        checks++;
        if (evq.size() != base + 7 * N + 1) begin
            errors++;
            $display("FAIL frame_events got=%0d required=%0d", evq.size() - base, 7 * N + 1);
        end else begin
            idx = base;
            prev = 0;
            for (int k = 0; k < N; k++) begin
                bit ok;
                ok = 1'b1;
                for (int j = 0; j < 7; j++) if (evq[idx + j].kind != j) ok = 1'b0;
                if (evq[idx + 1].cyc <= evq[idx].cyc || evq[idx + 2].cyc != evq[idx + 1].cyc + 1 ||
                    evq[idx + 3].cyc <= evq[idx + 2].cyc || evq[idx + 4].cyc != evq[idx + 3].cyc + 1 ||
                    evq[idx + 5].cyc <= evq[idx + 4].cyc || evq[idx + 6].cyc != evq[idx + 5].cyc + 1)
                    ok = 1'b0;
                if (evq[idx].cyc != ((k == 0) ? t + 1 : prev + 2)) ok = 1'b0;
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL pixel_sequence pix=%0d got kinds %0d%0d%0d%0d%0d%0d%0d win_go at %0d required 0123456 with 1-cycle go after done",
                             k, evq[idx].kind, evq[idx + 1].kind, evq[idx + 2].kind, evq[idx + 3].kind,
                             evq[idx + 4].kind, evq[idx + 5].kind, evq[idx + 6].kind, evq[idx].cyc);
                end
                checks++;
                if (evq[idx + 6].pix != k || evq[idx + 6].row != k / W || evq[idx + 6].col != k % W) begin
                    errors++;
                    $display("FAIL wr_position got pix=%0d row=%0d col=%0d required pix=%0d row=%0d col=%0d",
                             evq[idx + 6].pix, evq[idx + 6].row, evq[idx + 6].col, k, k / W, k % W);
                end
                prev = evq[idx + 6].cyc;
                idx += 7;
            end
            checks++;
            if (evq[idx].kind != K_FD || evq[idx].cyc != prev + 1) begin
                errors++;
                $display("FAIL frame_done_timing got kind=%0d cyc=%0d required kind=%0d cyc=%0d",
                         evq[idx].kind, evq[idx].cyc, K_FD, prev + 1);
            end
            checks++;
            if (evq[base + 150 * 7 + 6].pix != 150 || evq[base + 150 * 7 + 6].row != 1 ||
                evq[base + 150 * 7 + 6].col != 0) begin
                errors++;
                $display("FAIL column_wrap got pix=%0d row=%0d col=%0d required 150/1/0",
                         evq[base + 150 * 7 + 6].pix, evq[base + 150 * 7 + 6].row, evq[base + 150 * 7 + 6].col);
            end
            checks++;
            if (evq[idx - 1].pix != N - 1 || evq[idx - 1].row != H - 1 || evq[idx - 1].col != W - 1) begin
                errors++;
                $display("FAIL last_wr got pix=%0d row=%0d col=%0d required %0d/%0d/%0d",
                         evq[idx - 1].pix, evq[idx - 1].row, evq[idx - 1].col, N - 1, H - 1, W - 1);
            end
        end
        checks++;
        if (viol != v0) begin
            errors++;
            $display("FAIL exclusive_pulses got violations=%0d required=0", viol - v0);
        end
    endtask

    task automatic test_pause();
        int t;
        int p;
        int wg0;
        int wr0;
        resp_d = 0;
        pulse_start(t);
        for (int i = 0; i < 400 && !(sif.cdf_go && sif.pix_idx == 15'd10); i++) tick();
        checks++;
        if (!(sif.cdf_go && sif.pix_idx == 15'd10)) begin
            errors++;
            $display("FAIL pause_reach_cdf10 got pix=%0d cdf_go=%b required pix=10 cdf_go=1",
                     sif.pix_idx, sif.cdf_go);
        end
        pause = 1'b1;
        wg0 = n_ev[K_WG];
        wr0 = n_ev[K_WR];
        repeat (20) tick();
        checks++;
        if (n_ev[K_WR] != wr0 + 1 || last_pix[K_WR] != 10) begin
            errors++;
            $display("FAIL pause_pixel10_written got writes=%0d last_pix=%0d required writes=1 last_pix=10",
                     n_ev[K_WR] - wr0, last_pix[K_WR]);
        end
        checks++;
        if (n_ev[K_WG] != wg0 || busy !== 1'b1 || sif.pix_idx !== 15'd10) begin
            errors++;
            $display("FAIL pause_hold got win_go=%0d busy=%b pix=%0d required win_go=0 busy=1 pix=10",
                     n_ev[K_WG] - wg0, busy, sif.pix_idx);
        end
        pause = 1'b0;
        p = cyc;
        for (int i = 0; i < 10 && n_ev[K_WG] == wg0; i++) tick();
        checks++;
        if (n_ev[K_WG] != wg0 + 1 || last_cyc[K_WG] != p + 1 || last_pix[K_WG] != 11) begin
            errors++;
            $display("FAIL pause_release got win_go at +%0d pix=%0d required +1 pix=11",
                     last_cyc[K_WG] - p, last_pix[K_WG]);
        end
        do_reset();
    endtask

    task automatic test_stray();
        int t;
        int k0;
        int g;
        int h;
        int hg0;
        int wg0;
        int cg0;
        resp_d = 3;
        k0 = int'($urandom_range(6, 2));
        pulse_start(t);
        for (int i = 0; i < 200 && !(sif.win_go && sif.pix_idx == 15'(k0)); i++) tick();
        checks++;
        if (!(sif.win_go && sif.pix_idx == 15'(k0))) begin
            errors++;
            $display("FAIL stray_reach got pix=%0d required=%0d", sif.pix_idx, k0);
        end
        g = cyc;
        hg0 = n_ev[K_HG];
        s_win = 1'b1;
        tick();
        s_win = 1'b0;
        s_hist = 1'b1;
        tick();
        s_hist = 1'b0;
        for (int i = 0; i < 20 && n_ev[K_HG] == hg0; i++) tick();
        checks++;
        if (n_ev[K_HG] != hg0 + 1 || last_cyc[K_HG] != g + 4) begin
            errors++;
            $display("FAIL stray_in_win got hist_go count=%0d at +%0d required 1 at +4",
                     n_ev[K_HG] - hg0, last_cyc[K_HG] - g);
        end
        h = cyc;
        wg0 = n_ev[K_WG];
        cg0 = n_ev[K_CG];
        s_hist = 1'b1;
        tick();
        s_hist = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && n_ev[K_CG] == cg0; i++) tick();
        checks++;
        if (n_ev[K_CG] != cg0 + 1 || last_cyc[K_CG] != h + 4) begin
            errors++;
            $display("FAIL stray_in_hist got cdf_go count=%0d at +%0d required 1 at +4",
                     n_ev[K_CG] - cg0, last_cyc[K_CG] - h);
        end
        checks++;
        if (n_ev[K_WG] != wg0 || sif.pix_idx !== 15'(k0) || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_while_busy got win_go=%0d pix=%0d busy=%b required win_go=0 pix=%0d busy=1",
                     n_ev[K_WG] - wg0, sif.pix_idx, busy, k0);
        end
        do_reset();
    endtask

    task automatic test_reset_midframe();
        int t;
        int fd0;
        int wg0;
        int base;
        resp_d = 0;
        fd0 = n_ev[K_FD];
        pulse_start(t);
        for (int i = 0; i < 8000 && !(sif.hist_go && sif.pix_idx == 15'd500); i++) tick();
        checks++;
        if (!(sif.hist_go && sif.pix_idx == 15'd500)) begin
            errors++;
            $display("FAIL midframe_reach got pix=%0d hist_go=%b required pix=500 hist_go=1",
                     sif.pix_idx, sif.hist_go);
        end
        tick();
        #2;
        re = 1'b0;
        #1;
        checks++;
        if ({busy, frame_done, sif.win_go, sif.hist_go, sif.cdf_go, sif.wr_en} !== 6'b0 ||
            sif.row !== 8'd0 || sif.col !== 8'd0 || sif.pix_idx !== 15'd0) begin
            errors++;
            $display("FAIL async_reset got ctl=%b row=%0d col=%0d pix=%0d required all 0",
                     {busy, frame_done, sif.win_go, sif.hist_go, sif.cdf_go, sif.wr_en},
                     sif.row, sif.col, sif.pix_idx);
        end
        repeat (3) tick();
        re = 1'b1;
        wg0 = n_ev[K_WG];
        repeat (5) tick();
        checks++;
        if (busy !== 1'b0 || n_ev[K_FD] != fd0 || n_ev[K_WG] != wg0) begin
            errors++;
            $display("FAIL abandoned_frame got busy=%b frame_done=%0d win_go=%0d required 0/0/0",
                     busy, n_ev[K_FD] - fd0, n_ev[K_WG] - wg0);
        end
        base = evq.size();
        pulse_start(t);
        for (int i = 0; i < 200 && evq.size() < base + 7; i++) tick();
        checks++;
        if (evq.size() < base + 7) begin
            errors++;
            $display("FAIL restart_timeout got events=%0d required=7", evq.size() - base);
        end else if (evq[base].kind != K_WG || evq[base].cyc != t + 1 || evq[base].pix != 0 ||
                     evq[base + 6].kind != K_WR || evq[base + 6].pix != 0 ||
                     evq[base + 6].row != 0 || evq[base + 6].col != 0) begin
            errors++;
            $display("FAIL restart got first kind=%0d at +%0d pix=%0d wr kind=%0d pix=%0d required 0 at +1 pix 0, wr 6 pix 0",
                     evq[base].kind, evq[base].cyc - t, evq[base].pix, evq[base + 6].kind, evq[base + 6].pix);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_first_pixel();
        test_full_frame();
        test_pause();
        test_stray();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
